// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB-first, R times, with G-cycle zero gaps.
// Optional even-parity bit after each instance when SEQ_GEN_PARITY_EN is defined.
module seq_pattern_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
`ifdef SEQ_GEN_PARITY_EN
        , PAR = 2'd3
`endif
    } state_t;

    state_t             state_reg, state_next;
    logic [PAT_W-1:0]   pattern_reg, pattern_next;
    logic [CNT_W-1:0]   reps_reg, reps_next;
    logic [GAP_W-1:0]   gap_len_reg, gap_len_next;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               out_reg, out_next;
    logic               out_valid_reg, out_valid_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               end_of_inst;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            pattern_reg   <= '0;
            reps_reg      <= '0;
            gap_len_reg   <= '0;
            gap_cnt_reg   <= '0;
            idx_reg       <= '0;
            out_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pattern_reg   <= pattern_next;
            reps_reg      <= reps_next;
            gap_len_reg   <= gap_len_next;
            gap_cnt_reg   <= gap_cnt_next;
            idx_reg       <= idx_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pattern_next = pattern_reg;
        reps_next    = reps_reg;
        gap_len_next = gap_len_reg;
        gap_cnt_next = gap_cnt_reg;
        idx_next     = idx_reg;
        done_next    = 1'b0;
        end_of_inst  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    pattern_next = pattern_in;
                    reps_next    = repeat_cnt;
                    gap_len_next = gap_len;
                    if (repeat_cnt == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = SEND;
                        idx_next   = IDX_MSB;
                    end
                end
            end
            SEND: begin
                if (idx_reg == '0) begin
`ifdef SEQ_GEN_PARITY_EN
                    state_next = PAR;
`else
                    end_of_inst = 1'b1;
`endif
                end else begin
                    idx_next = idx_reg - IDX_W'(1);
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            PAR: begin
                end_of_inst = 1'b1;
            end
`endif
            GAP: begin
                if (gap_cnt_reg <= GAP_W'(1)) begin
                    gap_cnt_next = '0;
                    state_next   = SEND;
                    idx_next     = IDX_MSB;
                end else begin
                    gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // The last instance drops straight to IDLE; otherwise go through a gap only if one was asked for.
        if (end_of_inst) begin
            if (reps_reg <= CNT_W'(1)) begin
                reps_next  = '0;
                state_next = IDLE;
                done_next  = 1'b1;
            end else begin
                reps_next = reps_reg - CNT_W'(1);
                if (gap_len_reg != '0) begin
                    state_next   = GAP;
                    gap_cnt_next = gap_len_reg;
                end else begin
                    state_next = SEND;
                    idx_next   = IDX_MSB;
                end
            end
        end

        if (abort && (state_reg != IDLE)) begin
            state_next = IDLE;
            done_next  = 1'b0;
        end
    end

    // Outputs are registered from the next-state view so the first bit appears the cycle after start.
    always_comb begin
        out_next       = 1'b0;
        out_valid_next = 1'b0;
        busy_next      = (state_next != IDLE);
        case (state_next)
            SEND: begin
                out_next       = pattern_next[idx_next];
                out_valid_next = 1'b1;
            end
`ifdef SEQ_GEN_PARITY_EN
            PAR: begin
                out_next       = ^pattern_next;
                out_valid_next = 1'b1;
            end
`endif
            default: begin
                out_next       = 1'b0;
                out_valid_next = 1'b0;
            end
        endcase
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial pattern transmitter that emits a latched PAT_W-bit pattern MSB-first, one bit per clock, for a programmed number of repetitions with programmable zero-filled gaps between them. It is the driving end of the serial sequence-detector interface: its `out` connects directly to a detector's `in`, and `out_valid` qualifies each bit. It replaces hand-written stimulus sequences in detector testbenches and system-level links with a single programmable source.

## Interface
- PAT_W, 4, pattern width in bits (2..16)
- CNT_W, 4, width of repetition count
- GAP_W, 4, width of inter-pattern gap length
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, synchronous reset, active-high (fixed)
- start  input  1  begin burst; sampled only in IDLE
- pattern_in  input  PAT_W  pattern, latched on accepted start
- repeat_cnt  input  CNT_W  number of pattern instances R, latched on start (0 = empty burst)
- gap_len  input  GAP_W  gap cycles G between instances, latched on start
- abort  input  1  terminate burst immediately
- out  output  1  serial bit (registered)
- out_valid  output  1  high while `out` carries a pattern or parity bit
- busy  output  1  high from cycle after accepted start until burst ends
- done  output  1  one-cycle pulse after final bit of a completed burst

## Operation
- States: IDLE, SEND, PAR (only with macro), GAP.
- IDLE: out=0, out_valid=0, busy=0. On start=1: latch pattern_in/repeat_cnt/gap_len; if R=0 stay IDLE and pulse done next cycle; else go SEND, bit index = PAT_W-1, reps_left = R.
- SEND: out = pattern[bit index], out_valid=1; index decrements each cycle. After bit 0: go PAR if enabled, else end-of-instance.
- PAR: out = even parity bit of pattern, out_valid=1, one cycle, then end-of-instance.
- End-of-instance: decrement reps_left; if 0 -> IDLE with done pulse; else if G>0 -> GAP; else -> SEND with no idle cycle between instances.
- GAP: out=0, out_valid=0, busy=1 for exactly G cycles, then SEND.
- start while busy: ignored (latched values unchanged).
- abort=1 in any non-IDLE state: next cycle IDLE, out=0, out_valid=0, busy=0, no done pulse. abort has priority over start in the same cycle; abort in IDLE has no effect.
- Reset: all outputs 0, state IDLE, latched registers cleared; reset mid-burst behaves like abort without waiting for the current bit.
- Counters are unsigned; reps_left width CNT_W, gap counter width GAP_W; no wrap (counts stop at 0).

## Timing
- Start accepted at edge k -> first bit (pattern MSB) on out, with out_valid=1, busy=1, during cycle k+1.
- Each bit held exactly one cycle.
- Burst busy length: R*(PAT_W+P) + (R-1)*G cycles, P = 1 with parity else 0.
- done=1 for the single cycle immediately after the last valid bit; busy=0 in that cycle; start is accepted in that same cycle (back-to-back bursts, zero dead cycles beyond the done cycle).
- R=0: done pulses in cycle k+1; out_valid never asserts.

## Configuration
- SEQ_GEN_PARITY_EN defined: PAR state compiled in; each instance is followed by one even-parity bit (XOR of pattern bits) with out_valid=1, before any gap.
- Not defined: PAR state and parity logic absent; instances are exactly PAT_W bits.

## Test plan
- Reset held 2 cycles, then released -> out=0, out_valid=0, busy=0, done=0; start pulse with reset=1 ignored.
- pattern_in=4'b1011, R=2, G=2 (no macro) -> out over 10 cycles 1,0,1,1,0,0,1,0,1,1, out_valid 1111001111, done pulse on cycle 11; fed into 1011 Mealy detector -> exactly 2 detections.
- pattern_in=4'b1011, R=3, G=0 -> 12 contiguous valid bits 101110111011, busy 12 cycles, done on cycle 13; start on done cycle begins new burst next cycle.
- R=2, abort asserted on 3rd bit -> out_valid=0 and busy=0 next cycle, no done pulse; start mid-burst ignored, latched pattern unchanged.
- R=0 start -> done pulse next cycle, out_valid never 1.
- SEQ_GEN_PARITY_EN, pattern 4'b1011, R=1 -> out 1,0,1,1,1 with out_valid high 5 cycles, done on cycle 6; pattern 4'b1001 -> parity bit 0.
